// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   MEM-stage bridge between the CPU load/store path and up to DEV_NUM
//   memory-mapped devices in a single 256-byte I/O window.
//   - cpu_addr[31:8] == DEV_BASE selects the window (cpu_hit).
//   - cpu_addr[7:4] selects the device slot (16 bytes per slot).
//   - The access waits for dev_ready of the selected slot. It gives up with
//     a bus error if ready is still low once TIMEOUT extra cycles have
//     passed.
//   - dev_irq lines are synchronised onto hw_int for CP0.
//
// Ports
//   clk, reset        system clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata/be   MEM-stage request
//   cpu_hit           combinational window decode
//   cpu_stall         pipeline freeze while an access is pending
//   cpu_rdata         last load data (0 after an error)
//   cpu_rvalid        one-cycle completion pulse
//   bus_err           one-cycle error pulse, coincident with cpu_rvalid
//   dev_sel/we/addr/wdata/be   device-side request, held for the access
//   dev_rdata/ready   per-slot read data and completion
//   dev_irq           per-slot level interrupts (asynchronous)
//   hw_int            CP0 HWInt[7:2]
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no access pending; a hit request is decoded this cycle
// ST_ACCESS | device selected, waiting for its ready or the timeout
// ST_DONE   | completion cycle: rvalid (and bus_err) pulse, stall released

module mem_io_bridge #(
    parameter int          DEV_NUM  = 4,
    parameter logic [23:0] DEV_BASE = 24'h00007F,
    parameter int          TIMEOUT  = 15,
    parameter int          IRQ_SYNC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic                  cpu_hit,
    output logic                  cpu_stall,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  bus_err,
    output logic [DEV_NUM-1:0]    dev_sel,
    output logic                  dev_we,
    output logic [31:0]           dev_addr,
    output logic [31:0]           dev_wdata,
    output logic [3:0]            dev_be,
    input  logic [32*DEV_NUM-1:0] dev_rdata,
    input  logic [DEV_NUM-1:0]    dev_ready,
    input  logic [DEV_NUM-1:0]    dev_irq,
    output logic [5:0]            hw_int
);

    localparam int N_IRQ = (DEV_NUM < 6) ? DEV_NUM : 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  req_idx;
    logic        mapped;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    assign cpu_hit = (cpu_addr[31:8] == DEV_BASE);
    assign req_idx = cpu_addr[7:4];
    assign mapped  = cpu_hit && (int'(req_idx) < DEV_NUM);

    // Ready and read data of the registered slot; other slots are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < DEV_NUM; k++) begin
            if (int'(idx_q) == k) begin
                sel_ready = dev_ready[k];
                sel_rdata = dev_rdata[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && cpu_hit) begin
                    if (mapped) begin
                        we_d    = cpu_we;
                        idx_d   = req_idx;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        be_d    = cpu_be;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready on the terminal-count cycle still wins over the timeout.
                if (sel_ready) begin
                    if (!we_q) begin
                        rdata_d = sel_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        dev_sel = '0;
        if (state_q == ST_ACCESS) begin
            for (int k = 0; k < DEV_NUM; k++) begin
                if (int'(idx_q) == k) begin
                    dev_sel[k] = 1'b1;
                end
            end
        end
    end

    // The IDLE term lets the pipeline freeze in the same cycle the hit is seen.
    assign cpu_stall  = (state_q == ST_ACCESS) ||
                        ((state_q == ST_IDLE) && cpu_req && cpu_hit);
    assign cpu_rvalid = (state_q == ST_DONE);
    assign bus_err    = (state_q == ST_DONE) && err_q;
    assign cpu_rdata  = rdata_q;
    assign dev_we     = (state_q == ST_ACCESS) && we_q;
    assign dev_addr   = addr_q;
    assign dev_wdata  = wdata_q;
    assign dev_be     = be_q;

    // Interrupt synchroniser; only the lines that map onto HWInt are kept.
    logic [N_IRQ-1:0] irq_s1_q;
    logic [N_IRQ-1:0] irq_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_s1_q <= '0;
        end else begin
            irq_s1_q <= dev_irq[N_IRQ-1:0];
        end
    end

    generate
        if (IRQ_SYNC != 0) begin : g_sync2
            logic [N_IRQ-1:0] irq_s2_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    irq_s2_q <= '0;
                end else begin
                    irq_s2_q <= irq_s1_q;
                end
            end
            assign irq_sync = irq_s2_q;
        end else begin : g_sync1
            assign irq_sync = irq_s1_q;
        end
    endgenerate

    always_comb begin
        hw_int = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            hw_int[k] = irq_sync[k];
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

    localparam int NDEV = 4;
    localparam int TMO  = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic                cpu_req, cpu_we;
    logic [31:0]         cpu_addr, cpu_wdata;
    logic [3:0]          cpu_be;
    logic                cpu_hit, cpu_stall, cpu_rvalid, bus_err;
    logic [31:0]         cpu_rdata;
    logic [NDEV-1:0]     dev_sel;
    logic                dev_we;
    logic [31:0]         dev_addr, dev_wdata;
    logic [3:0]          dev_be;
    logic [32*NDEV-1:0]  dev_rdata;
    logic [NDEV-1:0]     dev_ready, dev_irq;
    logic [5:0]          hw_int;

    mem_io_bridge #(
        .DEV_NUM (NDEV),
        .DEV_BASE(24'h00007F),
        .TIMEOUT (TMO),
        .IRQ_SYNC(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_hit   (cpu_hit),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .bus_err   (bus_err),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_be    (dev_be),
        .dev_rdata (dev_rdata),
        .dev_ready (dev_ready),
        .dev_irq   (dev_irq),
        .hw_int    (hw_int)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rv_last = 0;
    int          rv_prev = 0;
    logic [31:0] mdl_rdata = '0;   // reference: data of last completed load

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Scoreboard monitor: every completion pulse is matched to the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && cpu_rvalid === 1'b1) begin
            rv_prev = rv_last;
            rv_last = cyc;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_rvalid: got rvalid=1, want no pending access");
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", cpu_rdata, mon_e.rdata);
                chk("bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
            end
        end
        if (bus_err === 1'b1 && cpu_rvalid !== 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL lone_bus_err: got bus_err=1 rvalid=0, want coincident");
        end
    end

    task automatic idle(input int n);
        cpu_req   = 1'b0;
        dev_ready = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One CPU access, called at posedge+1. dly = ACCESS cycles before ready.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int dly, input logic [31:0] rd_val);
        bit          hit, mapped, done, first;
        int          idx, exp_acc, exp_stall, stall_cnt, sel_cnt, acc;
        logic [3:0]  mask;
        exp_t        e;
        hit    = (addr[31:8] == 24'h00007F);
        idx    = int'(addr[7:4]);
        mapped = hit && (idx < NDEV);
        mask   = 4'(32'd1 << idx);
        for (int k = 0; k < NDEV; k++) dev_rdata[k*32 +: 32] = $urandom;
        if (mapped) dev_rdata[idx*32 +: 32] = rd_val;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_be    = be;
        dev_ready = 4'($urandom) & ~mask;

        exp_acc   = 0;
        exp_stall = 0;
        if (hit && !mapped) begin
            exp_stall = 1;
            mdl_rdata = '0;
            e = '{rdata: 32'h0, err: 1'b1};
        end else if (mapped) begin
            exp_acc   = (dly > TMO) ? TMO + 1 : dly + 1;
            exp_stall = exp_acc + 1;
            if (dly > TMO) mdl_rdata = '0;
            else if (!we)  mdl_rdata = rd_val;
            e = '{rdata: mdl_rdata, err: (dly > TMO)};
        end
        if (hit) exp_q.push_back(e);

        stall_cnt = 0; sel_cnt = 0; acc = 0; done = 0; first = 1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (first) begin
                chk("cpu_hit", {31'b0, cpu_hit}, {31'b0, hit});
                first = 0;
            end
            if (!cpu_stall) begin
                done = 1;
            end else begin
                stall_cnt++;
                if (dev_sel != 0) begin
                    sel_cnt++;
                    chk("dev_sel", {28'b0, dev_sel}, {28'b0, mask});
                    chk("dev_we", {31'b0, dev_we}, {31'b0, we});
                    chk("dev_addr", dev_addr, addr);
                    chk("dev_wdata", dev_wdata, wd);
                    chk("dev_be", {28'b0, dev_be}, {28'b0, be});
                end
                @(posedge clk);
                #1;
                dev_ready = 4'($urandom) & ~mask;
                if (dev_sel != 0) begin
                    if (acc == dly) dev_ready = dev_ready | mask;
                    acc++;
                end
            end
        end
        if (!done) chk("txn_bound", 32'd1, 32'd0);
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("sel_cycles", sel_cnt, exp_acc);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_txn();
        int          kind, r, dly;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        if (kind <= 6) begin
            a = {24'h00007F, 4'($urandom_range(0, NDEV - 1)), 4'($urandom)};
        end else if (kind == 7) begin
            a = {24'h00007F, 4'($urandom_range(NDEV, 15)), 4'($urandom)};
        end else begin
            a = $urandom;
            if (a[31:8] == 24'h00007F) a[31] = 1'b1;
        end
        r   = $urandom_range(0, 9);
        dly = (r < 7) ? $urandom_range(0, 4) : $urandom_range(TMO - 2, TMO + 3);
        do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), dly, $urandom);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    endtask

    // hw_int must show dev_irq as sampled two rising edges earlier.
    task automatic irq_rand();
        logic [3:0] p1, p2, v;
        p1 = '0;
        p2 = '0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #3;
            v = 4'($urandom);
            dev_irq = v;
            @(negedge clk);
            chk("hw_int", {26'b0, hw_int}, {28'b0, p2});
            p2 = p1;
            p1 = v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
        dev_rdata = '0;
        dev_ready = '0;
        dev_irq   = '0;

        #12;
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_dev_sel", {28'b0, dev_sel}, 32'd0);
        chk("rst_dev_we", {31'b0, dev_we}, 32'd0);
        chk("rst_dev_addr", dev_addr, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_hw_int", {26'b0, hw_int}, 32'd0);
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_txn(1'b0, 32'h0000_7F14, 32'h0, 4'hF, 0, 32'hDEADBEEF);
        idle(2);
        do_txn(1'b1, 32'h0000_7F20, 32'h12345678, 4'b0011, 3, 32'hA5A5A5A5);
        idle(2);
        do_txn(1'b0, 32'h0000_7F30, 32'h0, 4'hF, 1000, 32'h55AA55AA);
        idle(1);
        do_txn(1'b0, 32'h0000_7F50, 32'h0, 4'hF, 0, 32'h0);
        idle(1);
        do_txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 32'h0);
        idle(2);
        do_txn(1'b0, 32'h0000_7F04, 32'h0, 4'hF, 0, 32'h11111111);
        do_txn(1'b0, 32'h0000_7F14, 32'h0, 4'hF, 0, 32'h22222222);
        chk("b2b_spacing", rv_last - rv_prev, 32'd3);
        idle(1);
        do_txn(1'b0, 32'h0000_7F38, 32'h0, 4'hF, TMO, 32'hCAFEF00D);
        do_txn(1'b0, 32'h0000_7F08, 32'h0, 4'hF, TMO + 1, 32'h0BADF00D);
        do_txn(1'b1, 32'h0000_7F24, 32'hFEEDFACE, 4'b1100, TMO - 1, 32'h0);
        idle(2);

        @(posedge clk);
        #3;
        dev_irq = 4'b0001;
        @(negedge clk);
        chk("irq_0edge", {26'b0, hw_int}, 32'd0);
        @(negedge clk);
        chk("irq_1edge", {26'b0, hw_int}, 32'd0);
        @(negedge clk);
        chk("irq_2edge", {26'b0, hw_int}, 32'd1);
        dev_irq = '0;
        repeat (3) @(posedge clk);
        #1;

        fork
            irq_rand();
            begin
                repeat (50) rand_txn();
            end
        join
        idle(2);

        // Reset in the middle of an access: no completion may follow.
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_7F24;
        cpu_be    = 4'hF;
        dev_ready = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_pre_sel", {28'b0, dev_sel}, 32'd4);
        cpu_req = 1'b0;
        reset   = 1'b0;
        #1;
        chk("arst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("arst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        chk("arst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("arst_dev_sel", {28'b0, dev_sel}, 32'd0);
        chk("arst_dev_we", {31'b0, dev_we}, 32'd0);
        chk("arst_dev_addr", dev_addr, 32'd0);
        chk("arst_dev_wdata", dev_wdata, 32'd0);
        chk("arst_dev_be", {28'b0, dev_be}, 32'd0);
        chk("arst_rdata", cpu_rdata, 32'd0);
        chk("arst_hw_int", {26'b0, hw_int}, 32'd0);
        mdl_rdata = '0;
        dev_irq   = '0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        do_txn(1'b1, 32'h0000_7F04, 32'h01020304, 4'hF, 1, 32'h0);
        idle(3);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
